// File: rtl/addsub_pkg.sv
// addsub_pkg: FSM state and op encodings shared by addsub_seq and nibble_addsub
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;
endpackage

// File: rtl/nibble_addsub.sv
// nibble_addsub: 4-bit add/sub stage; x,y,cin,op in; s (nibble), cout (carry or borrow) out
module nibble_addsub
  import addsub_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  input  logic       op,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] r;
  // bit 4 of the 5-bit difference is the borrow-out
  assign r = (op == OP_ADD) ? {1'b0, x} + {1'b0, y} + {4'b0, cin}
                            : {1'b0, x} - {1'b0, y} - {4'b0, cin};
  assign s = r[3:0];
  assign cout = r[4];
endmodule

// File: rtl/addsub_seq.sv
// addsub_seq: nibble-serial adder/subtractor; clk, rst_n (sync, active-low), start/op/a/b in; ready/busy/done/result/carry out
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry
);
  state_t state, state_n;
  logic [3:0] idx;
  logic [W-1:0] a_q, b_q, acc, acc_n;
  logic op_q, c_q, cout, last;
  logic [3:0] x, y, s;
  assign x = 4'(a_q >> (4 * idx));
  assign y = 4'(b_q >> (4 * idx));
  assign last = idx == 4'(NIBBLES - 1);
  // replace nibble idx of the accumulator with the stage output
  assign acc_n = (acc & ~(W'(4'hF) << (4 * idx))) | (W'(s) << (4 * idx));
  nibble_addsub u_stage (.x(x), .y(y), .cin(c_q), .op(op_q), .s(s), .cout(cout));
  always_comb begin
    state_n = state;
    ready = state == IDLE;
    busy = state == RUN;
    done = state == DONE;
    state_n = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      acc <= '0;
      c_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      op_q <= OP_SUB;
      result <= '0;
      carry <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        a_q <= a;
        b_q <= b;
        op_q <= op;
        idx <= '0;
        c_q <= 1'b0;
      end
      if (state == RUN) begin
        acc <= acc_n;
        c_q <= cout;
        idx <= idx + 4'd1;
        if (last) begin
          result <= acc_n;
          carry <= cout;
        end
      end
    end
  end
endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
- REQ-001 The block SHALL have parameter NIBBLES, default 4: the number of 4-bit digits per operand; legal range 1..8.
- REQ-002 The block SHALL have localparam W = 4*NIBBLES: the operand and result width.
- REQ-003 Port clk SHALL be an input, width 1: the single clock; all state changes on its rising edge.
- REQ-004 Port rst_n SHALL be an input, width 1: reset, synchronous and active-low.
- REQ-005 Port start SHALL be an input, width 1: operation request, sampled only while ready=1.
- REQ-006 Port op SHALL be an input, width 1: operation select; 1 = add (a+b), 0 = subtract (a-b).
- REQ-007 Port a SHALL be an input, width W: first operand.
- REQ-008 Port b SHALL be an input, width W: second operand.
- REQ-009 Port ready SHALL be an output, width 1: high in IDLE, when the block can accept start.
- REQ-010 Port busy SHALL be an output, width 1: high in RUN.
- REQ-011 Port done SHALL be an output, width 1: one-cycle pulse when result and carry are updated.
- REQ-012 Port result SHALL be an output, width W: registered sum or difference, held until the next done.
- REQ-013 Port carry SHALL be an output, width 1: carry-out on add, borrow-out on subtract; held with result.

Function
- REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
- REQ-015 IDLE SHALL go to RUN on an edge with start=1, latching a, b and op, clearing nibble index idx to 0 and clearing the internal carry/borrow.
- REQ-016 IDLE SHALL stay in IDLE when start=0.
- REQ-017 Each RUN edge SHALL process nibble idx (LSB nibble first) through one shared 4-bit add/sub stage.
- REQ-018 That RUN edge SHALL store the stage's 4-bit output into accumulator nibble idx, register the stage's carry/borrow-out as the next nibble's carry/borrow-in, and increment idx.
- REQ-019 RUN SHALL last exactly NIBBLES edges; the edge processing nibble NIBBLES-1 SHALL move the FSM to DONE.
- REQ-020 On that same edge, result SHALL load the full accumulator (including the final nibble) and carry SHALL load the final carry/borrow-out.
- REQ-021 DONE SHALL assert done for exactly one cycle, then go to IDLE unconditionally.
- REQ-022 Latency: start sampled at edge E0 SHALL give done=1 in the cycle after edge E(NIBBLES).
- REQ-023 Throughput: one operation SHALL take NIBBLES+2 cycles.
- REQ-024 Add: each stage SHALL compute sum = a_n + b_n + cin, with cout = majority carry.
- REQ-025 Subtract: each stage SHALL compute diff = a_n - b_n - bin, with bout = (~a&b)|(bin&b)|(bin&~a) per bit.
- REQ-026 Final carry=1 on subtract SHALL mean a < b unsigned; the result is the W-bit two's-complement wrap.
- REQ-027 Wrap-around: result SHALL be modulo 2^W; overflow SHALL be reported only via carry.
- REQ-028 start while busy or in DONE SHALL be ignored, with no effect on latched operands.
- REQ-029 Changes on a, b or op after acceptance SHALL have no effect on the current operation.
- REQ-030 result and carry SHALL change only on the edge entering DONE, and SHALL be stable in IDLE and RUN.

Reset
- REQ-031 rst_n=0 on an edge SHALL force IDLE and clear idx, the accumulator, the internal carry, result, carry and done.
- REQ-032 Reset values SHALL be: ready=1, busy=0, done=0, result=0, carry=0.
- REQ-033 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; the first start after release SHALL be accepted normally.

Structure
- REQ-034 The state encoding (IDLE/RUN/DONE) and the op encodings OP_ADD=1 / OP_SUB=0 SHALL live in a shared package, addsub_pkg.
- REQ-035 The nibble datapath SHALL be one combinational sub-module, nibble_addsub, with inputs x[3:0], y[3:0], cin and op, and outputs s[3:0] and cout, instantiated once and shared across cycles.

Verification (NIBBLES=4)
- REQ-036 Add 0x00FF + 0x0001 SHALL give result=0x0100, carry=0, with done exactly 5 edges after start was sampled.
- REQ-037 Add 0xFFFF + 0x0001 SHALL give result=0x0000, carry=1; add 0x1234 + 0x4321 SHALL give 0x5555, carry=0.
- REQ-038 Sub 0x1000 - 0x0001 SHALL give 0x0FFF, carry=0; sub 0x0001 - 0x0002 SHALL give 0xFFFF, carry=1.
- REQ-039 start pulsed with new operands at cycles 2 and 3 after acceptance SHALL be ignored: the first result is unchanged, there is only one done pulse, and ready returns 1 after DONE.
- REQ-040 rst_n=0 for one edge while busy=1 SHALL give no done pulse and result=0; a following add 0x0003 + 0x0004 SHALL give 0x0007.
